// File: rtl/pld_demux_onehot_if.sv
// Bus bundle for pld_demux_onehot: one input beat stream fanned out to WIDTH output channels.
// err_flag/err_cnt exist only when PLD_DEMUX_ERR_CHK_EN is defined.
interface pld_demux_onehot_if #(
  parameter int WIDTH     = 4,
  parameter int PLD_WIDTH = 32
);
  logic                 in_vld;
  logic                 in_rdy;
  logic [WIDTH-1:0]     in_dest_onehot;
  logic [PLD_WIDTH-1:0] in_pld;
  logic [WIDTH-1:0]     v_out_vld;
  logic [WIDTH-1:0]     v_out_rdy;
  logic [PLD_WIDTH-1:0] v_out_pld [WIDTH];
`ifdef PLD_DEMUX_ERR_CHK_EN
  logic                 err_flag;
  logic [7:0]           err_cnt;

  modport master (
    output in_vld, in_dest_onehot, in_pld, v_out_rdy,
    input  in_rdy, v_out_vld, v_out_pld, err_flag, err_cnt
  );
  modport slave (
    input  in_vld, in_dest_onehot, in_pld, v_out_rdy,
    output in_rdy, v_out_vld, v_out_pld, err_flag, err_cnt
  );
`else
  modport master (
    output in_vld, in_dest_onehot, in_pld, v_out_rdy,
    input  in_rdy, v_out_vld, v_out_pld
  );
  modport slave (
    input  in_vld, in_dest_onehot, in_pld, v_out_rdy,
    output in_rdy, v_out_vld, v_out_pld
  );
`endif
endinterface

// File: rtl/pld_demux_onehot.sv
// One-hot payload demux: each channel owns a single output register that can drain and reload in one cycle.
// Define PLD_DEMUX_ERR_CHK_EN to drop zero/multi-hot destinations and count them instead of broadcasting.
module pld_demux_onehot #(
  parameter int WIDTH     = 4,
  parameter int PLD_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  pld_demux_onehot_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0]     vld_q;
  logic [WIDTH-1:0]     chan_free;
  logic [WIDTH-1:0]     load_mask;
  logic [PLD_WIDTH-1:0] pld_q [WIDTH];
  logic                 dest_ok;
  logic                 fire;

  // A channel can take a new beat if it is empty or being drained this cycle.
  assign chan_free = ~vld_q | bus.v_out_rdy;
  assign dest_ok   = &(chan_free | ~bus.in_dest_onehot);
  assign fire      = bus.in_vld & bus.in_rdy;

`ifdef PLD_DEMUX_ERR_CHK_EN
  logic       dest_legal;
  logic       err_flag_q;
  logic [7:0] err_cnt_q;

  assign dest_legal = (bus.in_dest_onehot != '0) &&
                      ((bus.in_dest_onehot & (bus.in_dest_onehot - ONE)) == '0);
  assign bus.in_rdy = dest_legal ? dest_ok : 1'b1;
  assign load_mask  = {WIDTH{fire & dest_legal}} & bus.in_dest_onehot;

  // Illegal beats are swallowed; the counter saturates so it never wraps back to a clean-looking value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag_q <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else if (fire && !dest_legal) begin
      err_flag_q <= 1'b1;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign bus.err_flag = err_flag_q;
  assign bus.err_cnt  = err_cnt_q;
`else
  // Multi-hot broadcasts atomically; an all-zero mask is accepted and vanishes.
  assign bus.in_rdy = dest_ok;
  assign load_mask  = {WIDTH{fire}} & bus.in_dest_onehot;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= load_mask | (vld_q & ~bus.v_out_rdy);
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pld_q[g] <= '0;
      end else if (load_mask[g]) begin
        pld_q[g] <= bus.in_pld;
      end
    end
    assign bus.v_out_pld[g] = pld_q[g];
  end

  assign bus.v_out_vld = vld_q;

endmodule

// File: tb/tb_pld_demux_onehot.sv
// Self-checking bench for pld_demux_onehot: directed scenarios plus random traffic against a per-channel model.
// Works with or without PLD_DEMUX_ERR_CHK_EN defined.
module tb_pld_demux_onehot;
  localparam int W  = 4;
  localparam int PW = 32;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pld_demux_onehot_if #(.WIDTH(W), .PLD_WIDTH(PW)) bus ();

  pld_demux_onehot #(.WIDTH(W), .PLD_WIDTH(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each channel is a one-deep slot that is either holding a beat or empty.
  bit        m_full [W];
  bit [31:0] m_data [W];
  bit        m_err_flag;
  int        m_err_cnt;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic [PW-1:0] p,
                               input logic [W-1:0] r);
    bus.in_vld         = v;
    bus.in_dest_onehot = d;
    bus.in_pld         = p;
    bus.v_out_rdy      = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int popCount(input logic [W-1:0] m);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(m[i]);
    return n;
  endfunction

  // Compare on the falling edge, then advance the model to what the next rising edge should produce.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < W; i++) begin
        m_full[i] = 1'b0;
        m_data[i] = '0;
      end
      m_err_flag = 1'b0;
      m_err_cnt  = 0;
      checkOutput("rst_vld", 64'(bus.v_out_vld), 64'd0);
      for (int i = 0; i < W; i++) checkOutput($sformatf("rst_pld%0d", i), 64'(bus.v_out_pld[i]), 64'd0);
    end else begin
      bit        blocked;
      bit        illegal;
      bit        exp_rdy;
      bit        accept;
      logic [W-1:0] exp_vld;
      blocked = 1'b0;
      for (int i = 0; i < W; i++)
        if (bus.in_dest_onehot[i] && m_full[i] && !bus.v_out_rdy[i]) blocked = 1'b1;
`ifdef PLD_DEMUX_ERR_CHK_EN
      illegal = (popCount(bus.in_dest_onehot) != 1);
`else
      illegal = 1'b0;
`endif
      exp_rdy = illegal ? 1'b1 : !blocked;
      checkOutput("in_rdy", 64'(bus.in_rdy), 64'(exp_rdy));
      for (int i = 0; i < W; i++) exp_vld[i] = m_full[i];
      checkOutput("v_out_vld", 64'(bus.v_out_vld), 64'(exp_vld));
      for (int i = 0; i < W; i++)
        if (m_full[i]) checkOutput($sformatf("pld%0d", i), 64'(bus.v_out_pld[i]), 64'(m_data[i]));
`ifdef PLD_DEMUX_ERR_CHK_EN
      checkOutput("err_flag", 64'(bus.err_flag), 64'(m_err_flag));
      checkOutput("err_cnt", 64'(bus.err_cnt), 64'(m_err_cnt));
`endif
      accept = bus.in_vld && exp_rdy;
      for (int i = 0; i < W; i++) begin
        if (bus.v_out_rdy[i]) m_full[i] = 1'b0;
        if (accept && !illegal && bus.in_dest_onehot[i]) begin
          m_full[i] = 1'b1;
          m_data[i] = bus.in_pld;
        end
      end
      if (accept && illegal) begin
        m_err_flag = 1'b1;
        if (m_err_cnt < 255) m_err_cnt++;
      end
    end
  end

  initial begin
    logic [W-1:0] d;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, '0);
    repeat (2) tick();
    checkOutput("reset_vld_lit", 64'(bus.v_out_vld), 64'd0);
    checkOutput("reset_pld1_lit", 64'(bus.v_out_pld[1]), 64'd0);
    rst_n = 1'b1;

    // Single beat to channel 1, visible exactly one edge later.
    applyStimulus(1'b1, 4'b0010, 32'hA5A5_0001, 4'b1111);
    checkOutput("ch1_vld_before", 64'(bus.v_out_vld), 64'd0);
    tick();
    checkOutput("ch1_vld_lit", 64'(bus.v_out_vld), 64'h2);
    checkOutput("ch1_pld_lit", 64'(bus.v_out_pld[1]), 64'hA5A5_0001);
    applyStimulus(1'b0, '0, '0, 4'b1111);
    tick();

    // Channel 2 stalled and full; a beat for channel 0 still goes through.
    applyStimulus(1'b1, 4'b0100, 32'h2222_0000, 4'b1011);
    tick();
    applyStimulus(1'b1, 4'b0100, 32'h2222_0001, 4'b1011);
    checkOutput("ch2_stall_rdy_lit", 64'(bus.in_rdy), 64'd0);
    tick();
    checkOutput("ch2_stable_lit", 64'(bus.v_out_pld[2]), 64'h2222_0000);
    applyStimulus(1'b1, 4'b0001, 32'h0000_00C0, 4'b1011);
    checkOutput("ch0_rdy_lit", 64'(bus.in_rdy), 64'd1);
    tick();
    checkOutput("ch0_vld_lit", 64'(bus.v_out_vld), 64'b0101);
    checkOutput("ch0_pld_lit", 64'(bus.v_out_pld[0]), 64'h0000_00C0);
    applyStimulus(1'b0, '0, '0, 4'b1111);
    tick();

    // Back-to-back drain-and-reload on channel 3 at one beat per cycle.
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 4'b1000, 32'hC300_0000 + 32'(k), 4'b1111);
      checkOutput("ch3_rdy_lit", 64'(bus.in_rdy), 64'd1);
      tick();
      checkOutput("ch3_vld_lit", 64'(bus.v_out_vld[3]), 64'd1);
      checkOutput("ch3_pld_lit", 64'(bus.v_out_pld[3]), 64'hC300_0000 + 64'(k));
    end
    applyStimulus(1'b0, '0, '0, 4'b1111);
    tick();

`ifdef PLD_DEMUX_ERR_CHK_EN
    applyStimulus(1'b1, 4'b0000, 32'hDEAD_0000, 4'b1111);
    checkOutput("err_zero_rdy_lit", 64'(bus.in_rdy), 64'd1);
    tick();
    applyStimulus(1'b1, 4'b0011, 32'hDEAD_0001, 4'b1111);
    checkOutput("err_multi_rdy_lit", 64'(bus.in_rdy), 64'd1);
    tick();
    checkOutput("err_flag_lit", 64'(bus.err_flag), 64'd1);
    checkOutput("err_cnt2_lit", 64'(bus.err_cnt), 64'd2);
    checkOutput("err_noload_lit", 64'(bus.v_out_vld), 64'd0);
    for (int k = 0; k < 300; k++) begin
      applyStimulus(1'b1, (k % 2 == 0) ? 4'b0000 : 4'b1111, 32'(k), 4'b1111);
      tick();
    end
    checkOutput("err_sat_lit", 64'(bus.err_cnt), 64'd255);
    applyStimulus(1'b0, '0, '0, 4'b1111);
    tick();
`else
    // Broadcast to channels 0 and 2, then the same mask blocked by a stalled channel 2.
    applyStimulus(1'b1, 4'b0101, 32'h5050_0101, 4'b1111);
    tick();
    checkOutput("bc_vld_lit", 64'(bus.v_out_vld), 64'b0101);
    checkOutput("bc_pld0_lit", 64'(bus.v_out_pld[0]), 64'h5050_0101);
    checkOutput("bc_pld2_lit", 64'(bus.v_out_pld[2]), 64'h5050_0101);
    applyStimulus(1'b1, 4'b0101, 32'h5050_0202, 4'b1011);
    checkOutput("bc_stall_rdy_lit", 64'(bus.in_rdy), 64'd0);
    tick();
    checkOutput("bc_stall_vld_lit", 64'(bus.v_out_vld), 64'b0100);
    checkOutput("bc_stall_pld0_lit", 64'(bus.v_out_pld[0]), 64'h5050_0101);
    applyStimulus(1'b0, '0, '0, 4'b1111);
    tick();
    applyStimulus(1'b1, 4'b0000, 32'hFFFF_0000, 4'b1111);
    checkOutput("zero_dest_rdy_lit", 64'(bus.in_rdy), 64'd1);
    tick();
    checkOutput("zero_dest_vld_lit", 64'(bus.v_out_vld), 64'd0);
`endif

    // Random traffic, mostly one-hot, with occasional resets.
    for (int k = 0; k < 2000; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: d = W'(1) << $urandom_range(0, W - 1);
        6, 7:             d = W'($urandom_range(0, 15));
        default:          d = '0;
      endcase
      rst_n = ($urandom_range(0, 199) != 0);
      applyStimulus(1'($urandom_range(0, 3) != 0), d, 32'($urandom), W'($urandom_range(0, 15)));
      tick();
    end
    rst_n = 1'b1;

    // Fill every channel, then pull reset between edges and expect outputs to clear at once.
    for (int i = 0; i < W; i++) begin
      applyStimulus(1'b1, W'(1) << i, 32'hF000_0000 + 32'(i), 4'b0000);
      tick();
    end
    applyStimulus(1'b0, '0, '0, 4'b0000);
    checkOutput("full_vld_lit", 64'(bus.v_out_vld), 64'hF);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_vld_lit", 64'(bus.v_out_vld), 64'd0);
    checkOutput("async_rst_pld3_lit", 64'(bus.v_out_pld[3]), 64'd0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'b0100, 32'h0BAD_CAFE, 4'b1111);
    tick();
    checkOutput("post_rst_vld_lit", 64'(bus.v_out_vld), 64'b0100);
    checkOutput("post_rst_pld_lit", 64'(bus.v_out_pld[2]), 64'h0BAD_CAFE);
    applyStimulus(1'b0, '0, '0, 4'b1111);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pld_demux_onehot.md
PLD_DEMUX_ONEHOT -- requirements
Module: pld_demux_onehot

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the number of output channels.
REQ-002 SHALL have parameter PLD_WIDTH, default 32, giving the payload width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_vld, input, 1 bit: input beat valid.
REQ-006 SHALL have port in_rdy, output, 1 bit: input beat accepted when in_vld and in_rdy are both high.
REQ-007 SHALL have port in_dest_onehot, input, WIDTH bits: destination channel mask.
REQ-008 SHALL have port in_pld, input, PLD_WIDTH bits: input payload.
REQ-009 SHALL have port v_out_vld, output, WIDTH bits: per-channel output valid.
REQ-010 SHALL have port v_out_rdy, input, WIDTH bits: per-channel output ready.
REQ-011 SHALL have port v_out_pld, output, unpacked array of WIDTH entries, PLD_WIDTH bits each: per-channel payload.
REQ-012 SHALL have port err_flag, output, 1 bit, present only with PLD_DEMUX_ERR_CHK_EN.
REQ-013 SHALL have port err_cnt, output, 8 bits, present only with PLD_DEMUX_ERR_CHK_EN.

Function
REQ-014 SHALL hold one output register (valid bit plus payload) per channel i.
REQ-015 Channel i SHALL be free when v_out_vld[i]==0 or v_out_rdy[i]==1, giving full-throughput pipeline-ready behaviour.
REQ-016 in_rdy SHALL be high when every channel selected by in_dest_onehot is free; unselected channels do not affect in_rdy.
REQ-017 On a fire (in_vld & in_rdy), every selected channel SHALL load in_pld and set its valid bit on the next edge: latency exactly 1 cycle.
REQ-018 Channel i SHALL clear its valid bit when v_out_vld[i] & v_out_rdy[i] and it is not reloaded in the same cycle; a simultaneous drain and load SHALL leave valid at 1 with the new payload.
REQ-019 v_out_pld[i] SHALL stay stable while v_out_vld[i]==1 and v_out_rdy[i]==0.
REQ-020 Without PLD_DEMUX_ERR_CHK_EN, a multi-hot in_dest_onehot SHALL broadcast the beat to all selected channels atomically; the beat is accepted only when all selected channels are free.
REQ-021 Without PLD_DEMUX_ERR_CHK_EN, an all-zero in_dest_onehot SHALL give in_rdy=1, and the beat is consumed and dropped.
REQ-022 Channels SHALL be independent: backpressure on one channel never stalls a beat destined only for others.
REQ-023 in_rdy SHALL be independent of in_vld and in_pld.

Reset
REQ-024 While rst_n==0, v_out_vld SHALL be all 0; v_out_pld, err_flag and err_cnt SHALL be 0.
REQ-025 Assertion of rst_n mid-transfer SHALL discard all held beats immediately; the first fire after deassertion SHALL behave as if from a fresh start.

Configuration
REQ-026 Macro PLD_DEMUX_ERR_CHK_EN SHALL enable illegal-destination checking.
REQ-027 With the macro, a beat is illegal if in_dest_onehot is zero or has more than one bit set.
REQ-028 With the macro, an illegal beat SHALL give in_rdy=1 and is dropped with no channel loaded.
REQ-029 With the macro, each illegal fire SHALL set err_flag (sticky until reset) and increment err_cnt, which saturates at 255.
REQ-030 Without the macro, REQ-020/021 SHALL apply and the err ports SHALL be absent.

Verification (WIDTH=4, PLD_WIDTH=32)
REQ-031 With dest=4'b0010, pld=32'hA5A5_0001 and all ready, the bench SHALL see v_out_vld=4'b0010 and v_out_pld[1]=A5A5_0001 exactly one cycle later.
REQ-032 With v_out_rdy[2]=0, ch2 full, and back-to-back beats to ch2 then ch0, the bench SHALL see in_rdy=0 for the ch2 beat and the ch0 beat still delivered once presented.
REQ-033 With ch3 full and v_out_rdy[3]=1 for the same cycle as a new ch3 beat, the bench SHALL see the beat accepted, v_out_vld[3] stay 1 and the payload update: 1 beat/cycle sustained over 16 beats.
REQ-034 With dest=4'b0101 and the macro off, the bench SHALL see ch0 and ch2 both loaded with the same payload; with ch2 stalled, in_rdy=0 and neither channel loaded.
REQ-035 With the macro on, dests 4'b0000 then 4'b0011 SHALL both be accepted and dropped, giving err_flag=1 and err_cnt=2; 300 illegal beats SHALL give err_cnt=255.
REQ-036 Asserting rst_n low with all 4 channels holding beats SHALL clear v_out_vld=0 asynchronously, before the next clock edge.
